// File: rtl/next_pc_unit.sv
// ----------------------------------------------------------------------------
// next_pc_unit
//
// Fetch-stage next-PC selection and program-counter register. The next PC is
// chosen among pc+1, a branch target (bra) and a register target (raa); a
// stall input freezes all state. When the RAS_EN macro is defined a circular
// return-address stack predicts subroutine-return targets for mc==2 + ret.
// With RAS_EN undefined the stack is not built, call/ret are ignored,
// ras_empty is tied to 1 and ras_mismatch to 0.
//
// Parameters:
//   WIDTH      PC/address width in bits
//   RAS_DEPTH  RAS entries (power of two, >= 2)
//   RESET_PC   PC value loaded on reset
//
// Ports:
//   clk           system clock, all updates on the rising edge
//   rst           synchronous active-high reset (overrides everything)
//   stall         hold pc and RAS this cycle
//   mc            next-PC select: 0 = pc+1, 1/3 = bra, 2 = raa (or RAS top)
//   bra           branch target
//   raa           register-jump target
//   call          push return address (only when mc != 0)
//   ret           pop return target (only when mc == 2)
//   pc            current PC (registered)
//   pc_1          pc + 1 (combinational, wraps)
//   ras_empty     RAS holds no entries
//   ras_mismatch  one-cycle registered pulse: last popped target != raa
// ----------------------------------------------------------------------------
module next_pc_unit #(
    parameter int               WIDTH     = 32,
    parameter int               RAS_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_PC  = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [1:0]       mc,
    input  logic [WIDTH-1:0] bra,
    input  logic [WIDTH-1:0] raa,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_1,
    output logic             ras_empty,
    output logic             ras_mismatch
);

    localparam logic [WIDTH-1:0] PC_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] pc_nxt_s;
    logic [WIDTH-1:0] ras_top_s;
    logic             pop_hit_s;
    logic             mismatch_nxt_s;
    logic             mismatch_r;

    assign pc           = pc_r;
    assign pc_1         = pc_r + PC_ONE;
    assign ras_mismatch = mismatch_r;

`ifdef RAS_EN
    localparam int              PTR_W   = $clog2(RAS_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   CNT_ONE = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(RAS_DEPTH);

    logic [WIDTH-1:0] ras_r [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_r;
    logic [PTR_W:0]   count_r;
    logic [PTR_W-1:0] ptr_nxt_s;
    logic [PTR_W:0]   count_nxt_s;
    logic [PTR_W-1:0] top_idx_s;
    logic [PTR_W-1:0] wr_idx_s;
    logic             wr_en_s;
    logic             push_req_s;
    logic             pop_req_s;

    assign top_idx_s  = ptr_r - PTR_ONE;
    assign ras_top_s  = ras_r[top_idx_s];
    assign ras_empty  = (count_r == {(PTR_W+1){1'b0}});
    assign push_req_s = call && (mc != 2'd0);
    assign pop_req_s  = ret && (mc == 2'd2);

    // RAS pointer/count update and entry write selection for this cycle
    always_comb begin
        ptr_nxt_s   = ptr_r;
        count_nxt_s = count_r;
        wr_en_s     = 1'b0;
        wr_idx_s    = ptr_r;
        pop_hit_s   = 1'b0;
        if (!stall) begin
            if (pop_req_s && !ras_empty) begin
                pop_hit_s = 1'b1;
                if (push_req_s) begin
                    // call+ret: replace the top entry in place
                    wr_en_s  = 1'b1;
                    wr_idx_s = top_idx_s;
                end else begin
                    ptr_nxt_s   = top_idx_s;
                    count_nxt_s = count_r - CNT_ONE;
                end
            end else if (push_req_s) begin
                // plain push; also covers call+ret on an empty stack
                wr_en_s   = 1'b1;
                wr_idx_s  = ptr_r;
                ptr_nxt_s = ptr_r + PTR_ONE;
                if (count_r == CNT_MAX) begin
                    count_nxt_s = count_r;   // overflow overwrites oldest
                end else begin
                    count_nxt_s = count_r + CNT_ONE;
                end
            end else begin
                ptr_nxt_s = ptr_r;
            end
        end else begin
            pop_hit_s = 1'b0;
        end
    end

    // RAS pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r   <= {PTR_W{1'b0}};
            count_r <= {(PTR_W+1){1'b0}};
        end else begin
            ptr_r   <= ptr_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    // RAS storage; contents are don't-care after reset, only writes are gated
    always_ff @(posedge clk) begin
        if (wr_en_s && !rst) begin
            ras_r[wr_idx_s] <= pc_1;
        end
    end
`else
    logic unused_s;

    assign ras_top_s = {WIDTH{1'b0}};
    assign pop_hit_s = 1'b0;
    assign ras_empty = 1'b1;
    assign unused_s  = ^{call, ret, (RAS_DEPTH > 1)};
`endif

    // Next-PC selection
    always_comb begin
        pc_nxt_s       = pc_1;
        mismatch_nxt_s = 1'b0;
        case (mc)
            2'd0:       pc_nxt_s = pc_1;
            2'd1, 2'd3: pc_nxt_s = bra;
            2'd2: begin
                if (pop_hit_s) begin
                    pc_nxt_s       = ras_top_s;
                    mismatch_nxt_s = (ras_top_s != raa);
                end else begin
                    pc_nxt_s = raa;
                end
            end
            default:    pc_nxt_s = pc_1;
        endcase
    end

    // Program counter and mismatch pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r       <= RESET_PC;
            mismatch_r <= 1'b0;
        end else if (stall) begin
            pc_r       <= pc_r;
            mismatch_r <= 1'b0;
        end else begin
            pc_r       <= pc_nxt_s;
            mismatch_r <= mismatch_nxt_s;
        end
    end

endmodule

// File: tb/tb_next_pc_unit.sv
module tb_next_pc_unit;

    localparam int          WIDTH     = 32;
    localparam int          RAS_DEPTH = 4;
    localparam logic [31:0] RESET_PC  = 32'h0;

    logic        clk = 1'b0;
    logic        rst, stall, call, ret;
    logic [1:0]  mc;
    logic [31:0] bra, raa;
    logic [31:0] pc, pc_1;
    logic        ras_empty, ras_mismatch;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [31:0] m_pc;
    logic [31:0] m_stack [$];
    logic        m_mis;

    next_pc_unit #(.WIDTH(WIDTH), .RAS_DEPTH(RAS_DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .stall(stall), .mc(mc), .bra(bra), .raa(raa),
        .call(call), .ret(ret), .pc(pc), .pc_1(pc_1),
        .ras_empty(ras_empty), .ras_mismatch(ras_mismatch)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance the model by one clock using the behavioural rules.
    task automatic model_step();
        logic [31:0] p1, nxt;
        logic        mis;
        if (rst) begin
            m_pc = RESET_PC;
            m_stack.delete();
            m_mis = 1'b0;
        end else if (stall) begin
            m_mis = 1'b0;
        end else begin
            p1  = m_pc + 32'd1;
            mis = 1'b0;
            nxt = (mc == 2'd0) ? p1 : (mc == 2'd2) ? raa : bra;
`ifdef RAS_EN
            if (mc == 2'd2 && ret && m_stack.size() > 0) begin
                nxt = m_stack[$];
                mis = (nxt != raa);
                if (call) m_stack[m_stack.size()-1] = p1;
                else void'(m_stack.pop_back());
            end else if (call && mc != 2'd0) begin
                m_stack.push_back(p1);
                if (m_stack.size() > RAS_DEPTH) void'(m_stack.pop_front());
            end
`endif
            m_pc  = nxt;
            m_mis = mis;
        end
    endtask

    task automatic cyc(input logic r, input logic s, input logic [1:0] m,
                       input logic [31:0] b, input logic [31:0] a,
                       input logic c, input logic t);
        rst = r; stall = s; mc = m; bra = b; raa = a; call = c; ret = t;
        model_step();
        @(posedge clk);
        #1;
        check("pc", pc, m_pc);
        check("pc_1", pc_1, m_pc + 32'd1);
        check("ras_empty", {31'd0, ras_empty}, {31'd0, m_stack.size() == 0});
        check("ras_mismatch", {31'd0, ras_mismatch}, {31'd0, m_mis});
    endtask

    initial begin
        m_pc = 32'h0; m_mis = 1'b0;
        // reset then count up
        cyc(1, 0, 0, 0, 0, 0, 0);
        check("reset_pc", pc, 32'h0);
        check("reset_empty", {31'd0, ras_empty}, 32'd1);
        for (int i = 1; i <= 4; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0);
            check("count_up", pc, 32'(i));
        end
        cyc(1, 1, 1, 32'h55, 0, 1, 0);
        check("reset_midrun", pc, 32'h0);
        // mux selections and stall
        cyc(0, 0, 1, 32'h40, 0, 0, 0); check("sel_bra1", pc, 32'h40);
        cyc(0, 0, 3, 32'h80, 0, 0, 0); check("sel_bra3", pc, 32'h80);
        cyc(0, 0, 2, 0, 32'h10, 0, 0); check("sel_raa", pc, 32'h10);
        cyc(0, 1, 1, 32'h99, 0, 0, 0); check("stall_hold", pc, 32'h10);
        // wraparound
        cyc(0, 0, 1, 32'hFFFF_FFFF, 0, 0, 0);
        check("pc_1_wrap", pc_1, 32'h0);
        cyc(0, 0, 0, 0, 0, 0, 0); check("pc_wrap", pc, 32'h0);
        // ret with possibly-empty RAS selects raa
        cyc(0, 0, 2, 0, 32'h7, 0, 1); check("ret_empty", pc, 32'h7);
        check("ret_empty_flag", {31'd0, ras_empty}, 32'd1);
`ifdef RAS_EN
        // call then matching return
        cyc(0, 0, 1, 32'h20, 0, 0, 0);
        cyc(0, 0, 1, 32'h100, 0, 1, 0); check("call", pc, 32'h100);
        check("call_nonempty", {31'd0, ras_empty}, 32'd0);
        cyc(0, 0, 2, 0, 32'h21, 0, 1); check("ret_match", pc, 32'h21);
        check("ret_match_mis", {31'd0, ras_mismatch}, 32'd0);
        // overflow: 5 pushes into depth 4, then 5 pops
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) cyc(0, 0, 1, 32'(i), 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 2, 0, 32'hAA, 0, 1);
            check("ovf_pop", pc, (i < 4) ? 32'(5 - i) : 32'hAA);
            check("ovf_mis", {31'd0, ras_mismatch}, (i < 4) ? 32'd1 : 32'd0);
        end
        // call+ret replaces the top in place
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 32'h10, 0, 0, 0);
        cyc(0, 0, 1, 32'h30, 0, 1, 0);
        cyc(0, 0, 1, 32'h50, 0, 1, 0);
        cyc(0, 1, 2, 0, 32'h99, 1, 1); check("cr_stall", pc, 32'h50);
        cyc(0, 0, 2, 0, 32'h99, 1, 1); check("cr_target", pc, 32'h31);
        cyc(0, 0, 2, 0, 32'h51, 0, 1); check("cr_newtop", pc, 32'h51);
        cyc(0, 0, 2, 0, 32'h11, 0, 1); check("cr_bottom", pc, 32'h11);
        check("cr_empty", {31'd0, ras_empty}, 32'd1);
`endif
        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic        r, s, c, t;
            logic [1:0]  m;
            logic [31:0] a;
            r = ($urandom_range(0, 63) == 0);
            s = ($urandom_range(0, 5) == 0);
            m = 2'($urandom_range(0, 3));
            c = ($urandom_range(0, 2) == 0);
            t = ($urandom_range(0, 1) == 0);
            a = $urandom;
            if (m_stack.size() > 0 && $urandom_range(0, 1) == 1) a = m_stack[$];
            cyc(r, s, m, $urandom, a, c, t);
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
